// File: rtl/or_map_engine.sv
// or_map_engine: sequential executor for OR-map descriptors.
// It ORs mem[modifier+i] into mem[origin+i] for each word of the descriptor,
// using a single-port RAM whose read data arrives one cycle after the strobe.
// Define ORMAP_OVERLAP_CHECK_EN to reject descriptors whose in-place overlap
// would feed earlier results into later reads; they finish at once with err=1.
module or_map_engine #(
    parameter int AW = 16,
    parameter int DW = 32,
    parameter int LW = 16,
    parameter int NF = 8,
    localparam int SW = $clog2(NF)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_origin,
    input  logic [AW-1:0] cmd_modifier,
    input  logic [LW-1:0] cmd_length,
    input  logic          cmd_cond_en,
    input  logic [SW-1:0] cmd_cond_sel,
    input  logic          cmd_cond_val,
    input  logic [NF-1:0] flags,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          done,
    output logic          skipped,
    output logic          err
);
    typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP_B, WR, FIN} state_t;

    state_t        state, nxt;
    logic [AW-1:0] org, mdf, idx_a;
    logic [LW-1:0] len, idx;
    logic [DW-1:0] a_q, b_q;
    logic          skip_q, err_q;
    logic          accept, cond_ok, hazard, last, go_fin;

    assign accept  = (state == IDLE) && cmd_valid;
    assign cond_ok = !cmd_cond_en || (flags[cmd_cond_sel] == cmd_cond_val);
    assign idx_a   = AW'(idx);
    assign last    = (idx == len - LW'(1));
    assign go_fin  = !cond_ok || (cmd_length == '0) || hazard;

`ifdef ORMAP_OVERLAP_CHECK_EN
    localparam int CW = ((AW > LW) ? AW : LW) + 1;
    logic [AW-1:0] gap;
    // Distance is only meaningful when modifier sits below origin, so it never wraps.
    assign gap    = cmd_origin - cmd_modifier;
    assign hazard = (cmd_modifier < cmd_origin) && (CW'(gap) < CW'(cmd_length));
`else
    assign hazard = 1'b0;
`endif

    // State register; reset aborts any command in flight without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Descriptor capture, word index and operand registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            org    <= '0;
            mdf    <= '0;
            len    <= '0;
            idx    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            skip_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                org    <= cmd_origin;
                mdf    <= cmd_modifier;
                len    <= cmd_length;
                idx    <= '0;
                skip_q <= !cond_ok;
                err_q  <= cond_ok && hazard;
            end
            if (state == RD_B)  a_q <= mem_rdata;
            if (state == CAP_B) b_q <= mem_rdata;
            if (state == WR)    idx <= idx + LW'(1);
        end
    end

    // Next-state decode and memory/completion outputs for the current state.
    always_comb begin
        nxt       = state;
        cmd_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        done      = 1'b0;
        skipped   = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) nxt = go_fin ? FIN : RD_A;
            end
            RD_A: begin
                mem_req  = 1'b1;
                mem_addr = org + idx_a;
                nxt      = RD_B;
            end
            RD_B: begin
                mem_req  = 1'b1;
                mem_addr = mdf + idx_a;
                nxt      = CAP_B;
            end
            CAP_B: nxt = WR;
            WR: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = org + idx_a;
                mem_wdata = a_q | b_q;
                nxt       = last ? FIN : RD_A;
            end
            FIN: begin
                done    = 1'b1;
                skipped = skip_q;
                err     = err_q;
                nxt     = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_or_map_engine.sv
// tb_or_map_engine: table-driven bench with a write scoreboard for or_map_engine.
module tb_or_map_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_cond_en, cmd_cond_val;
    logic [15:0] cmd_origin, cmd_modifier, cmd_length;
    logic [2:0]  cmd_cond_sel;
    logic [7:0]  flags;
    logic        mem_req, mem_we, done, skipped, err;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic        tb_we;
    logic [15:0] tb_addr;
    logic [31:0] tb_data;
    logic [31:0] ram [0:65535];

    typedef struct {
        logic [15:0] o, m, len;
        logic        ce;
        logic [2:0]  cs;
        logic        cv;
        logic [7:0]  fl;
        logic        sk;
    } vec_t;
    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    vec_t        vt [9];
    wr_t         q [$];
    logic [31:0] ov [logic [15:0]];
    int          pass_cnt = 0, chk_cnt = 0, nreq = 0;
    bit          mon_en = 1'b1;

`ifdef ORMAP_OVERLAP_CHECK_EN
    localparam bit OVC = 1'b1;
`else
    localparam bit OVC = 1'b0;
`endif

    or_map_engine dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_origin(cmd_origin), .cmd_modifier(cmd_modifier), .cmd_length(cmd_length),
        .cmd_cond_en(cmd_cond_en), .cmd_cond_sel(cmd_cond_sel), .cmd_cond_val(cmd_cond_val),
        .flags(flags), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .skipped(skipped), .err(err)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered read data; bench pokes use the same port.
    always @(posedge clk) begin
        if (tb_we) ram[tb_addr] <= tb_data;
        else if (mem_req) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Scoreboard: every DUT write is popped against the model's expected write.
    always @(negedge clk) begin
        if (mon_en && rst_n && mem_req) begin
            nreq++;
            if (mem_we) begin
                if (q.size() == 0) chk("unexpected_write", {16'd0, mem_addr, mem_wdata}, 64'd0);
                else begin
                    wr_t e;
                    e = q.pop_front();
                    chk("wr_addr", mem_addr, e.a);
                    chk("wr_data", mem_wdata, e.d);
                end
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < 50 && !cmd_ready; c++) @(negedge clk);
        chk("ready_before_cmd", cmd_ready, 1'b1);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        cmd_origin = v.o; cmd_modifier = v.m; cmd_length = v.len;
        cmd_cond_en = v.ce; cmd_cond_sel = v.cs; cmd_cond_val = v.cv; flags = v.fl;
        cmd_valid = 1'b1;
        nreq = 0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        flags = ~v.fl;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        logic [15:0] a, b;
        logic [31:0] x, y, o4, o5, o6;
        bit          ex_err, exec;
        int          cyc, exp_lat;
        for (int i = 0; i < v.len; i++) begin
            poke(v.o + 16'(i), $urandom);
            poke(v.m + 16'(i), $urandom);
        end
        if (k == 0) begin
            poke(16'd10, 32'h0000_00F0);
            poke(16'd20, 32'h0000_000F);
        end
        o4 = ram[4]; o5 = ram[5]; o6 = ram[6];
        ex_err  = OVC && !v.sk && (v.m < v.o) && ((v.o - v.m) < v.len);
        exec    = !v.sk && !ex_err && (v.len != 0);
        exp_lat = exec ? 4 * int'(v.len) + 1 : 1;
        ov.delete();
        if (exec) begin
            for (int i = 0; i < v.len; i++) begin
                a = v.o + 16'(i);
                b = v.m + 16'(i);
                x = ov.exists(a) ? ov[a] : ram[a];
                y = ov.exists(b) ? ov[b] : ram[b];
                ov[a] = x | y;
                q.push_back('{a, x | y});
            end
        end
        wait_ready();
        drive(v);
        cyc = 0;
        for (int c = 0; c < 4 * int'(v.len) + 10; c++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("ready_low_busy", cmd_ready, 1'b0);
            if (done) break;
        end
        chk("done_seen", done, 1'b1);
        chk("latency", cyc, exp_lat);
        chk("skipped", skipped, v.sk);
        chk("err", err, ex_err);
        chk("req_count", nreq, exec ? 3 * int'(v.len) : 0);
        chk("queue_empty", q.size(), 0);
        q.delete();
        foreach (ov[key]) chk("ram_result", ram[key], ov[key]);
        if (k == 0) begin
            chk("tp1_mem10", ram[10], 32'h0000_00FF);
            chk("tp1_mem20", ram[20], 32'h0000_000F);
        end
        if (k == 5 && !OVC) chk("chain_mem6", ram[6], o6 | o4 | o5);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("ready_after_done", cmd_ready, 1'b1);
    endtask

    initial begin
        logic [31:0] r300, r301, r302, r400;
        int          wc;
        bit          seen_done;
        vt[0] = '{16'd10,    16'd20,    16'd1, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[1] = '{16'h0100,  16'h0200,  16'd3, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[2] = '{16'h0140,  16'h0240,  16'd2, 1'b1, 3'd3, 1'b1, 8'h00, 1'b1};
        vt[3] = '{16'h0120,  16'h0220,  16'd2, 1'b1, 3'd3, 1'b1, 8'h08, 1'b0};
        vt[4] = '{16'hFFFF,  16'h0010,  16'd2, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[5] = '{16'd5,     16'd4,     16'd3, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[6] = '{16'h0030,  16'h0030,  16'd2, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[7] = '{16'h0050,  16'h0060,  16'd0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        vt[8] = '{16'h0070,  16'h0080,  16'd1, 1'b1, 3'd7, 1'b0, 8'h7F, 1'b0};
        rst_n = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
        cmd_valid = 1'b0; cmd_origin = '0; cmd_modifier = '0; cmd_length = '0;
        cmd_cond_en = 1'b0; cmd_cond_sel = '0; cmd_cond_val = 1'b0; flags = '0;
        #1;
        chk("rst_ready", cmd_ready, 1'b1);
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 16'd0);
        chk("rst_done", {done, skipped, err}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) run_vec(vt[k], k);

        // Reset during the write of word 1 of a 3-word command.
        for (int i = 0; i < 3; i++) begin
            poke(16'h0300 + 16'(i), $urandom);
            poke(16'h0400 + 16'(i), $urandom);
        end
        r300 = ram[16'h0300]; r301 = ram[16'h0301]; r302 = ram[16'h0302]; r400 = ram[16'h0400];
        mon_en = 1'b0;
        wait_ready();
        drive('{16'h0300, 16'h0400, 16'd3, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0});
        wc = 0;
        seen_done = 1'b0;
        for (int c = 0; c < 40 && wc < 2; c++) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
            if (mem_req && mem_we) wc++;
        end
        chk("rst_wr_index", mem_addr, 16'h0301);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {mem_req, mem_we}, 2'b00);
        chk("arst_addr", mem_addr, 16'd0);
        chk("arst_wdata", mem_wdata, 32'd0);
        chk("arst_ready", cmd_ready, 1'b1);
        chk("arst_done", {done, skipped, err}, 3'b000);
        chk("no_done_before_rst", seen_done, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_word0_kept", ram[16'h0300], r300 | r400);
        chk("rst_word1_clean", ram[16'h0301], r301);
        chk("rst_word2_clean", ram[16'h0302], r302);
        rst_n = 1'b1;
        mon_en = 1'b1;
        q.delete();
        run_vec(vt[1], 1);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
